// File: rtl/mem_master_pkg.sv
// Shared widths, FSM state encoding and address helper for the burst memory master.
package mem_master_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_ISSUE  = 2'd1,
    RD_DRAIN  = 2'd2,
    WR_ACCEPT = 2'd3
  } state_t;

  // Address space is a power of two, so plain overflow gives the wrap to 0.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + 1'b1;
  endfunction
endpackage

// File: rtl/mem_burst_cnt.sv
// Burst address/beat tracker: loads start address and length, steps with wrap, flags the last beat.
module mem_burst_cnt
  import mem_master_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [LEN_W-1:0] beat;
  logic [LEN_W-1:0] len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      beat <= '0;
      len  <= '0;
    end else if (load) begin
      addr <= load_addr;
      beat <= '0;
      len  <= load_len;
    end else if (inc) begin
      addr <= addr_inc(addr);
      beat <= beat + 1'b1;
    end
  end

  assign last = (beat == len);
endmodule

// File: rtl/mem_master.sv
// Single-outstanding burst master: 1..4 beat reads/writes against a registered-read memory port.
module mem_master
  import mem_master_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              wr_done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t            state;
  logic              accept, wr_acc;
  logic              cnt_inc, cnt_last;
  logic [ADDR_W-1:0] cnt_addr;
  logic              done_pend;
  // Issue-to-data pipeline: [0] memory access cycle, [1] unused spare kept zero.
  logic [1:0]        vld_pipe;
  logic              lst_pend;

  assign accept  = req_valid && req_ready;
  assign wr_acc  = wr_valid && wr_ready;
  assign cnt_inc = ((state == RD_ISSUE) && !cnt_last) || wr_acc;

  mem_burst_cnt u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .inc       (cnt_inc),
    .load_addr (req_addr),
    .load_len  (req_len),
    .addr      (cnt_addr),
    .last      (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
      wr_done   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done_pend <= 1'b0;
      vld_pipe  <= '0;
      lst_pend  <= 1'b0;
    end else begin
      wr_done   <= 1'b0;
      mem_write <= 1'b0;
      // Memory returns data the cycle after the strobe; capture it on the edge after that.
      vld_pipe  <= {1'b0, mem_read};
      lst_pend  <= mem_read && cnt_last;
      rd_valid  <= vld_pipe[0];
      rd_last   <= lst_pend;
      if (vld_pipe[0]) rd_data <= mem_rdata;

      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (req_write) begin
              state    <= WR_ACCEPT;
              wr_ready <= 1'b1;
            end else begin
              state    <= RD_ISSUE;
              mem_read <= 1'b1;
              mem_addr <= req_addr;
            end
          end else begin
            // Also covers the post-reset cycle and the write-completion cycle.
            req_ready <= 1'b1;
            wr_done   <= done_pend;
            done_pend <= 1'b0;
          end
        end
        RD_ISSUE: begin
          if (cnt_last) begin
            mem_read <= 1'b0;
            state    <= RD_DRAIN;
          end else begin
            mem_addr <= addr_inc(cnt_addr);
          end
        end
        RD_DRAIN: begin
          if (rd_last) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        WR_ACCEPT: begin
          if (wr_acc) begin
            mem_write <= 1'b1;
            mem_addr  <= cnt_addr;
            mem_wdata <= wr_data;
            if (cnt_last) begin
              wr_ready  <= 1'b0;
              state     <= IDLE;
              done_pend <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_master.sv
// Table-driven bench for mem_master with a registered-read memory and cycle-stamped scoreboards.
module tb_mem_master;
  import mem_master_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [1:0]  req_len = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [7:0]  wr_data = '0;
  logic        rd_valid, rd_last, wr_done, mem_read, mem_write;
  logic [7:0]  rd_data, mem_wdata, mem_rdata;
  logic [4:0]  mem_addr;

  mem_master dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .wr_done(wr_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: samples strobes at the edge, read data registered one edge later.
  logic [7:0] mem [32];
  logic       inited = 1'b0;
  always @(posedge clk) begin
    if (!inited) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h80 + i[7:0];
      inited <= 1'b1;
    end else begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
      if (mem_read)  mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct packed { logic [4:0] a; logic [7:0] d; logic l; int c; } exp_t;
  typedef struct { logic wr; logic [4:0] addr; logic [1:0] len; logic [3:0][7:0] d; int gap; } vec_t;

  exp_t wq[$], rq[$], dq[$];
  int   doneq[$];
  int   total = 0, bad = 0, cyc = 0;
  vec_t tbl[9];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0][7:0] mk(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: every strobe/beat must match the next expected entry, including its cycle.
  always @(negedge clk) if (rst_n) begin
    exp_t e;
    int   c;
    if (mem_read && mem_write) begin bad++; $display("FAIL strobe_overlap at cyc %0d", cyc); end
    if (rd_valid && req_ready) begin bad++; $display("FAIL rd_valid_with_req_ready at cyc %0d", cyc); end
    if (rd_last && !rd_valid) begin bad++; $display("FAIL rd_last_without_valid at cyc %0d", cyc); end
    if (mem_write) begin
      if (wq.size() == 0) begin bad++; $display("FAIL unexpected_mem_write addr %0d at cyc %0d", mem_addr, cyc); end
      else begin
        e = wq.pop_front();
        chk("wr_strobe{cyc,addr,data}", {cyc[15:0], 3'b0, mem_addr, mem_wdata}, {e.c[15:0], 3'b0, e.a, e.d});
      end
    end
    if (mem_read) begin
      if (rq.size() == 0) begin bad++; $display("FAIL unexpected_mem_read addr %0d at cyc %0d", mem_addr, cyc); end
      else begin
        e = rq.pop_front();
        chk("rd_strobe{cyc,addr}", {cyc[15:0], 11'b0, mem_addr}, {e.c[15:0], 11'b0, e.a});
      end
    end
    if (rd_valid) begin
      if (dq.size() == 0) begin bad++; $display("FAIL unexpected_rd_valid data %0h at cyc %0d", rd_data, cyc); end
      else begin
        e = dq.pop_front();
        chk("rd_beat{cyc,last,data}", {cyc[15:0], 7'b0, rd_last, rd_data}, {e.c[15:0], 7'b0, e.l, e.d});
      end
    end
    if (wr_done) begin
      if (doneq.size() == 0) begin bad++; $display("FAIL unexpected_wr_done at cyc %0d", cyc); end
      else begin
        c = doneq.pop_front();
        chk("wr_done{cyc,req_ready}", {cyc[15:0], 15'b0, req_ready}, {c[15:0], 15'b0, 1'b1});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 60) begin @(negedge clk); n++; end
    if (!req_ready) begin total++; bad++; $display("FAIL timeout waiting for req_ready"); end
  endtask

  task automatic push_read(logic [4:0] a, logic [1:0] len, logic [3:0][7:0] d, int acc);
    for (int k = 0; k <= int'(len); k++) begin
      rq.push_back('{a: 5'(a + k), d: 8'h0, l: 1'b0, c: acc + 1 + k});
      dq.push_back('{a: 5'h0, d: d[k], l: (k == int'(len)), c: acc + 3 + k});
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with req_ready high again.
  task automatic do_req(vec_t v);
    int acc, n;
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_len = v.len;
    wait_ready();
    acc = cyc;
    if (!v.wr) push_read(v.addr, v.len, v.d, acc);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_addr = 5'($urandom); req_len = 2'($urandom); req_write = 1'($urandom);
    if (v.wr) begin
      for (int k = 0; k <= int'(v.len); k++) begin
        wr_valid = 1'b1; wr_data = v.d[k];
        n = 0;
        while (!wr_ready && n < 20) begin @(negedge clk); n++; end
        if (!wr_ready) begin total++; bad++; $display("FAIL timeout waiting for wr_ready beat %0d", k); end
        wq.push_back('{a: 5'(v.addr + k), d: v.d[k], l: 1'b0, c: cyc + 1});
        if (k == int'(v.len)) doneq.push_back(cyc + 2);
        @(posedge clk); @(negedge clk);
        if (k == v.gap) begin
          wr_valid = 1'b0; wr_data = 8'($urandom);
          @(posedge clk); @(negedge clk);
        end
      end
      wr_valid = 1'b0;
    end
    wait_ready();
  endtask

  initial begin
    int acc, n, c;
    tbl[0] = '{1'b1, 5'd3,  2'd0, mk(8'hA5, 8'h00, 8'h00, 8'h00), -1};
    tbl[1] = '{1'b0, 5'd3,  2'd0, mk(8'hA5, 8'h00, 8'h00, 8'h00), -1};
    tbl[2] = '{1'b1, 5'd30, 2'd3, mk(8'd11, 8'd22, 8'd33, 8'd44), -1};
    tbl[3] = '{1'b0, 5'd30, 2'd3, mk(8'd11, 8'd22, 8'd33, 8'd44), -1};
    tbl[4] = '{1'b1, 5'd12, 2'd1, mk(8'h77, 8'h88, 8'h00, 8'h00), 0};
    tbl[5] = '{1'b0, 5'd12, 2'd1, mk(8'h77, 8'h88, 8'h00, 8'h00), -1};
    tbl[6] = '{1'b0, 5'd20, 2'd2, mk(8'h94, 8'h95, 8'h96, 8'h00), -1};
    tbl[7] = '{1'b1, 5'd31, 2'd1, mk(8'hDE, 8'hAD, 8'h00, 8'h00), -1};
    tbl[8] = '{1'b0, 5'd31, 2'd1, mk(8'hDE, 8'hAD, 8'h00, 8'h00), -1};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {4'b0, req_ready, wr_ready, rd_valid, rd_last, wr_done, mem_read, mem_write,
                          mem_addr, mem_wdata, rd_data}, 32'h0);
    rst_n = 1'b1;
    #1 chk("req_ready_before_first_edge", {31'b0, req_ready}, 32'h0);
    @(negedge clk);
    chk("req_ready_after_reset", {31'b0, req_ready}, 32'h1);

    for (int i = 0; i < 9; i++) do_req(tbl[i]);

    // Request held during a read: the second one waits for the cycle after rd_last.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd30; req_len = 2'd3;
    wait_ready();
    acc = cyc;
    push_read(5'd30, 2'd3, mk(8'd11, 8'hDE, 8'hAD, 8'd44), acc);
    @(posedge clk); @(negedge clk);
    req_addr = 5'd3; req_len = 2'd0;
    n = 0;
    while (!req_ready && n < 30) begin @(negedge clk); n++; end
    chk("held_req_accept_cycle", cyc, acc + 7);
    push_read(5'd3, 2'd0, mk(8'hA5, 8'h00, 8'h00, 8'h00), cyc);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    wait_ready();

    // Stray write data while idle must be ignored.
    wr_valid = 1'b1; wr_data = 8'h5C;
    repeat (2) begin
      chk("wr_ready_idle", {31'b0, wr_ready}, 32'h0);
      @(negedge clk);
    end
    wr_valid = 1'b0;

    // Reset while beat 1 of a 4-beat write is on the memory port.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd8; req_len = 2'd3;
    wait_ready();
    c = cyc;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; wr_valid = 1'b1; wr_data = 8'hC0;
    chk("wr_ready_first_beat", {31'b0, wr_ready}, 32'h1);
    wq.push_back('{a: 5'd8, d: 8'hC0, l: 1'b0, c: c + 2});
    @(posedge clk); @(negedge clk);
    wr_data = 8'hC1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("mid_burst_reset_outputs", {4'b0, req_ready, wr_ready, rd_valid, rd_last, wr_done, mem_read,
                                        mem_write, mem_addr, mem_wdata, rd_data}, 32'h0);
    wr_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("req_ready_held_low_at_release", {31'b0, req_ready}, 32'h0);
    @(negedge clk);
    chk("req_ready_after_mid_reset", {31'b0, req_ready}, 32'h1);
    do_req('{1'b0, 5'd8, 2'd1, mk(8'hC0, 8'h89, 8'h00, 8'h00), -1});

    repeat (3) @(negedge clk);
    chk("wr_queue_drained", wq.size(), 0);
    chk("rd_strobe_queue_drained", rq.size(), 0);
    chk("rd_beat_queue_drained", dq.size(), 0);
    chk("done_queue_drained", doneq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 SHALL declare clk  input  1  rising-edge system clock.
REQ-002 SHALL declare rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL declare req_valid  input  1  burst request offered.
REQ-004 SHALL declare req_ready  output  1  request accepted when req_valid&&req_ready at a clk edge.
REQ-005 SHALL declare req_write  input  1  1=write burst, 0=read burst.
REQ-006 SHALL declare req_addr  input  5  burst start address.
REQ-007 SHALL declare req_len  input  2  beats minus one (1..4 beats).
REQ-008 SHALL declare wr_valid  input  1  write-data beat offered.
REQ-009 SHALL declare wr_ready  output  1  write-data beat accepted when wr_valid&&wr_ready at a clk edge.
REQ-010 SHALL declare wr_data  input  8  write-data beat.
REQ-011 SHALL declare rd_valid  output  1  read-data beat present, one cycle, no backpressure.
REQ-012 SHALL declare rd_data  output  8  read-data beat.
REQ-013 SHALL declare rd_last  output  1  marks final read beat.
REQ-014 SHALL declare wr_done  output  1  one-cycle pulse after final write issued.
REQ-015 SHALL declare mem_read, mem_write  output  1 each  memory strobes.
REQ-016 SHALL declare mem_addr  output  5, mem_wdata  output  8, mem_rdata  input  8  memory port; memory samples strobes and returns read data registered one edge later.

Function
REQ-017 All outputs SHALL be registered; mem_read and mem_write SHALL never be 1 in the same cycle.
REQ-018 States SHALL be IDLE, RD_ISSUE, RD_DRAIN, WR_ACCEPT; req_ready=1 only in IDLE, wr_ready=1 only in WR_ACCEPT.
REQ-019 Request accept at edge E0 SHALL latch write flag, address, beat count.
REQ-020 Read: mem_read=1 with mem_addr=A+k on cycles 1..len+1 after E0 (back-to-back), then RD_DRAIN.
REQ-021 Read: mem_rdata SHALL be captured one cycle after each issue; beat k SHALL appear as rd_valid=1, rd_data=mem[A+k] in cycle 3+k; rd_last=1 with final beat only.
REQ-022 IDLE SHALL be re-entered so req_ready=1 in the cycle after the rd_last cycle.
REQ-023 Write: each beat accepted at an edge SHALL drive mem_write=1, mem_addr=A+k, mem_wdata=beat in the following cycle; back-to-back beats sustain one write per cycle; wr_valid gaps insert idle cycles (mem_write=0).
REQ-024 Write: after final beat accepted, wr_ready SHALL drop next cycle; wr_done=1 in the cycle after the final mem_write cycle, coincident with req_ready=1.
REQ-025 Address SHALL increment modulo 32 (31 wraps to 0).
REQ-026 req_valid while busy SHALL be ignored (not accepted, not queued); wr_valid outside WR_ACCEPT SHALL be ignored.
REQ-027 Inputs req_addr/req_len/req_write SHALL be don't-care except at the accept edge.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, beat counter 0, and req_ready=0, wr_ready=0, rd_valid=0, rd_last=0, wr_done=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, rd_data=0.
REQ-029 req_ready SHALL become 1 in the first cycle after rst_n deasserts.
REQ-030 Reset mid-burst SHALL abandon the burst with no further strobes; beats already written stay written; no rd_last/wr_done issued.

Structure
REQ-031 Package mem_master_pkg SHALL hold ADDR_W=5, DATA_W=8, LEN_W=2 and the state enum.
REQ-032 Address/beat counting SHALL be one sub-module, mem_burst_cnt (load, increment-with-wrap, last-beat flag).

Verification
REQ-033 Single write addr 3 data 8'hA5 then single read addr 3 -> mem_write cycle 2 after accept; rd_valid cycle 3 after read accept, rd_data=8'hA5, rd_last=1.
REQ-034 Write burst addr 30 len 3 data 11,22,33,44 continuous -> mem_addr 30,31,0,1 on consecutive cycles; wr_done once; read-back burst returns 11,22,33,44 on four consecutive cycles.
REQ-035 Write burst len 1 with one-cycle wr_valid gap -> one idle cycle between mem_write pulses; memory contents correct.
REQ-036 req_valid held high during a read burst -> second request accepted only in the cycle after rd_last; strobes never overlap.
REQ-037 rst_n pulsed low during second beat of a 4-beat write -> all outputs 0 immediately; only beat 0 (and beat 1 if its mem_write already fired) present in memory; req_ready=1 after release.
REQ-038 Assertion across all tests: never mem_read&&mem_write; rd_valid never while req_ready.
